// File: rtl/split_line_coupler_if.sv
// Memory-style request/response bundle shared by the word side and the line side
// of the split line coupler; LINE_BYTES sets the data width of each instance.
interface mem_if #(
  parameter int LINE_BYTES   = 64,
  parameter int ADDRESS_SIZE = 32
);
  logic [ADDRESS_SIZE-1:0] addr;
  logic [8*LINE_BYTES-1:0] data_i;
  logic [8*LINE_BYTES-1:0] data_o;
  logic [LINE_BYTES-1:0]   data_en;
  logic                    read_en;
  logic                    write_en;
  logic                    hit;
  logic                    done;

  // Handshake: the requester holds addr/data_i/data_en/enables steady until it sees
  // the one-cycle done pulse (hit and data_o are valid with it), then drops its
  // enables on the following cycle.
  modport bus (
    input  addr, data_i, data_en, read_en, write_en,
    output data_o, hit, done
  );

  modport driver (
    output addr, data_i, data_en, read_en, write_en,
    input  data_o, hit, done
  );
endinterface

// File: rtl/split_line_coupler.sv
// Turns one word-wide access into one or two line-wide accesses, splitting words that
// straddle a line boundary and reassembling read bytes from both lines.
module split_line_coupler #(
  parameter int WORD_BYTES   = 4,
  parameter int LINE_BYTES   = 64,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  mem_if.bus         short_in_if,
  mem_if.driver      long_out_if,
  output logic [2:0] state_dbg
);

  localparam int WW    = 8 * WORD_BYTES;
  localparam int LW    = 8 * LINE_BYTES;
  localparam int OFF_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [ADDRESS_SIZE-1:0] OFF_MASK = ADDRESS_SIZE'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, FIRST, GAP, SECOND, RESP} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] cap_addr;
  logic [WW-1:0]           cap_data;
  logic [WORD_BYTES-1:0]   cap_en;
  logic                    cap_rd;
  logic                    cap_wr;
  logic                    hit_acc;
  logic [LW-1:0]           line0;
  logic [OFF_W-1:0]        in_off;
  logic [OFF_W-1:0]        cap_off;

  assign in_off    = (LINE_BYTES > 1) ? short_in_if.addr[OFF_W-1:0] : '0;
  assign cap_off   = (LINE_BYTES > 1) ? cap_addr[OFF_W-1:0] : '0;
  assign state_dbg = state;

  function automatic logic crosses(input logic [OFF_W-1:0] off);
    return (int'(off) + WORD_BYTES) > LINE_BYTES;
  endfunction

  function automatic logic [LW-1:0] lo_data(input logic [WW-1:0] d, input logic [OFF_W-1:0] off);
    logic [LW-1:0] w;
    w = LW'(d);
    return w << (8 * int'(off));
  endfunction

  function automatic logic [LINE_BYTES-1:0] lo_en(input logic [WORD_BYTES-1:0] e, input logic [OFF_W-1:0] off);
    logic [LINE_BYTES-1:0] w;
    w = LINE_BYTES'(e);
    return w << int'(off);
  endfunction

  // Upper part of a straddling word: the bytes that did not fit in the first line.
  function automatic logic [LW-1:0] hi_data(input logic [WW-1:0] d, input logic [OFF_W-1:0] off);
    logic [WW-1:0] s;
    s = d >> (8 * (LINE_BYTES - int'(off)));
    return LW'(s);
  endfunction

  function automatic logic [LINE_BYTES-1:0] hi_en(input logic [WORD_BYTES-1:0] e, input logic [OFF_W-1:0] off);
    logic [WORD_BYTES-1:0] s;
    s = e >> (LINE_BYTES - int'(off));
    return LINE_BYTES'(s);
  endfunction

  // pair = {second line, first line}; word byte i is pair byte offset+i.
  function automatic logic [WW-1:0] assemble(input logic [2*LW-1:0] pair, input logic [OFF_W-1:0] off);
    logic [2*LW-1:0] s;
    s = pair >> (8 * int'(off));
    return s[WW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cap_addr             <= '0;
      cap_data             <= '0;
      cap_en               <= '0;
      cap_rd               <= 1'b0;
      cap_wr               <= 1'b0;
      hit_acc              <= 1'b1;
      line0                <= '0;
      short_in_if.data_o   <= '0;
      short_in_if.done     <= 1'b0;
      short_in_if.hit      <= 1'b0;
      long_out_if.addr     <= '0;
      long_out_if.data_i   <= '0;
      long_out_if.data_en  <= '0;
      long_out_if.read_en  <= 1'b0;
      long_out_if.write_en <= 1'b0;
    end else begin
      short_in_if.done <= 1'b0;
      short_in_if.hit  <= 1'b0;
      case (state)
        IDLE: begin
          if (short_in_if.read_en || short_in_if.write_en) begin
            cap_addr             <= short_in_if.addr;
            cap_data             <= short_in_if.data_i;
            cap_en               <= short_in_if.data_en;
            cap_rd               <= short_in_if.read_en;
            cap_wr               <= short_in_if.write_en;
            hit_acc              <= 1'b1;
            long_out_if.addr     <= short_in_if.addr & ~OFF_MASK;
            long_out_if.data_i   <= lo_data(short_in_if.data_i, in_off);
            long_out_if.data_en  <= lo_en(short_in_if.data_en, in_off);
            long_out_if.read_en  <= short_in_if.read_en;
            long_out_if.write_en <= short_in_if.write_en;
            state                <= FIRST;
          end
        end
        FIRST: begin
          if (long_out_if.done) begin
            long_out_if.addr     <= '0;
            long_out_if.data_i   <= '0;
            long_out_if.data_en  <= '0;
            long_out_if.read_en  <= 1'b0;
            long_out_if.write_en <= 1'b0;
            hit_acc              <= hit_acc & long_out_if.hit;
            line0                <= long_out_if.data_o;
            if (crosses(cap_off)) begin
              state <= GAP;
            end else begin
              state            <= RESP;
              short_in_if.done <= 1'b1;
              short_in_if.hit  <= hit_acc & long_out_if.hit;
              if (cap_rd) short_in_if.data_o <= assemble({{LW{1'b0}}, long_out_if.data_o}, cap_off);
            end
          end
        end
        GAP: begin
          long_out_if.addr     <= (cap_addr & ~OFF_MASK) + ADDRESS_SIZE'(LINE_BYTES);
          long_out_if.data_i   <= hi_data(cap_data, cap_off);
          long_out_if.data_en  <= hi_en(cap_en, cap_off);
          long_out_if.read_en  <= cap_rd;
          long_out_if.write_en <= cap_wr;
          state                <= SECOND;
        end
        SECOND: begin
          if (long_out_if.done) begin
            long_out_if.addr     <= '0;
            long_out_if.data_i   <= '0;
            long_out_if.data_en  <= '0;
            long_out_if.read_en  <= 1'b0;
            long_out_if.write_en <= 1'b0;
            hit_acc              <= hit_acc & long_out_if.hit;
            short_in_if.done     <= 1'b1;
            short_in_if.hit      <= hit_acc & long_out_if.hit;
            if (cap_rd) short_in_if.data_o <= assemble({long_out_if.data_o, line0}, cap_off);
            state                <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_line_coupler.sv
// Directed and randomized accesses against a byte-addressed memory model; the bench
// plays both the word requester and the line memory.
module tb_split_line_coupler;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  mem_if #(.LINE_BYTES(4),  .ADDRESS_SIZE(32)) sif ();
  mem_if #(.LINE_BYTES(64), .ADDRESS_SIZE(32)) lif ();

  split_line_coupler #(.WORD_BYTES(4), .LINE_BYTES(64), .ADDRESS_SIZE(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .short_in_if (sif),
    .long_out_if (lif),
    .state_dbg   (state_dbg)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] prev_data_o;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [511:0] line_rd(input logic [31:0] la);
    logic [511:0] r;
    for (int j = 0; j < 64; j++) r[8*j +: 8] = mem_rd(la + 32'(j));
    return r;
  endfunction

  // One word access: expected line transactions are derived byte by byte from the
  // word address, the line memory answers after lat cycles, and the word result is
  // checked against the model memory contents taken before the access.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en,
                           input logic rd, input logic wr, input int lat,
                           input logic h1, input logic h2, input bit perturb, input bit abort);
    logic [31:0]  ln [2];
    logic [63:0]  xen [2];
    logic [511:0] xdat [2];
    logic [31:0]  word;
    logic [31:0]  ba;
    int           ntx, tx, wait_c, cyc, last_done, k, pos;
    bit           fin;
    ln[0] = a & 32'hFFFF_FFC0;
    ln[1] = ln[0] + 32'd64;
    xen[0] = '0; xen[1] = '0; xdat[0] = '0; xdat[1] = '0;
    for (int i = 0; i < 4; i++) begin
      ba  = a + 32'(i);
      k   = ((ba & 32'hFFFF_FFC0) == ln[0]) ? 0 : 1;
      pos = int'(ba[5:0]);
      xen[k][pos]          = en[i];
      xdat[k][8*pos +: 8]  = d[8*i +: 8];
      word[8*i +: 8]       = mem_rd(ba);
    end
    ntx = ((int'(a[5:0]) + 4) > 64) ? 2 : 1;
    if (rd) exp_q.push_back(word);
    sif.addr = a; sif.data_i = d; sif.data_en = en; sif.read_en = rd; sif.write_en = wr;
    tx = 0; wait_c = 0; cyc = 0; last_done = -10; fin = 0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      lif.done = 1'b0; lif.hit = 1'b0; lif.data_o = '0;
      if (perturb && cyc == 2) begin
        sif.addr = $urandom; sif.data_i = $urandom; sif.data_en = 4'($urandom);
      end
      if (cyc == 1) chk("first_starts", {lif.read_en, lif.write_en}, {rd, wr});
      if (cyc == last_done + 1) chk("long_en_low_after_done", {lif.read_en, lif.write_en}, 2'b00);
      if (sif.done) begin
        chk("done_latency", cyc, last_done + 1);
        chk("txn_count", tx, ntx);
        chk("short_hit", sif.hit, h1 & ((ntx == 2) ? h2 : 1'b1));
        if (rd) prev_data_o = exp_q.pop_front();
        chk("data_o", sif.data_o, prev_data_o);
        sif.read_en = 1'b0; sif.write_en = 1'b0;
        fin = 1;
      end else begin
        chk("short_hit_quiet", sif.hit, 1'b0);
        chk("data_o_held", sif.data_o, prev_data_o);
        if ((lif.read_en || lif.write_en) && cyc != last_done + 1) begin
          if (abort && tx == 1) begin
            reset = 1'b1; sif.read_en = 1'b0; sif.write_en = 1'b0;
            @(negedge clk);
            chk("abort_long_en", {lif.read_en, lif.write_en}, 2'b00);
            chk("abort_long_addr", lif.addr, 32'h0);
            chk("abort_short_done", sif.done, 1'b0);
            chk("abort_data_o", sif.data_o, 32'h0);
            reset = 1'b0;
            if (rd) void'(exp_q.pop_back());
            prev_data_o = '0;
            repeat (3) begin
              @(negedge clk);
              chk("abort_no_done", sif.done, 1'b0);
            end
            fin = 1;
          end else if (wait_c >= lat) begin
            if (tx >= ntx) begin
              chk("extra_txn", tx, ntx - 1);
            end else begin
              if (tx == 1) chk("gap_one_cycle", cyc - wait_c, last_done + 2);
              chk("long_addr", lif.addr, ln[tx]);
              chk("long_data_i", lif.data_i, xdat[tx]);
              chk("long_data_en", lif.data_en, xen[tx]);
              chk("long_enables", {lif.read_en, lif.write_en}, {rd, wr});
              lif.done = 1'b1;
              lif.hit = (tx == 0) ? h1 : h2;
              lif.data_o = line_rd(lif.addr);
              if (lif.write_en)
                for (int j = 0; j < 64; j++)
                  if (lif.data_en[j]) mem[lif.addr + 32'(j)] = lif.data_i[8*j +: 8];
              tx++; wait_c = 0; last_done = cyc;
            end
          end else begin
            wait_c++;
          end
        end
      end
    end
    if (!fin) chk("done_timeout", 1'b0, 1'b1);
    if (!abort) begin
      @(negedge clk);
      chk("done_single_pulse", sif.done, 1'b0);
      chk("data_o_after", sif.data_o, prev_data_o);
    end
  endtask

  initial begin
    logic [31:0] ra, rdat;
    logic [3:0]  ren;
    logic [1:0]  rw;
    reset = 1'b1;
    sif.addr = '0; sif.data_i = '0; sif.data_en = '0; sif.read_en = 1'b0; sif.write_en = 1'b0;
    lif.data_o = '0; lif.hit = 1'b0; lif.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_long_outputs", {lif.addr, lif.data_en, lif.read_en, lif.write_en}, '0);
    chk("reset_long_data", lif.data_i, '0);
    chk("reset_short", {sif.done, sif.hit, sif.data_o}, '0);
    chk("reset_state_idle", state_dbg, 3'd0);
    reset = 1'b0;
    prev_data_o = '0;

    // Aligned read
    mem[32'h1004] = 8'hEF; mem[32'h1005] = 8'hBE; mem[32'h1006] = 8'hAD; mem[32'h1007] = 8'hDE;
    do_access(32'h1004, 32'h0, 4'h0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 0, 0);
    chk("aligned_read_value", sif.data_o, 32'hDEADBEEF);

    // Crossing write
    do_access(32'h103E, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1, 1'b1, 1'b1, 0, 0);
    chk("cross_write_mem", {mem_rd(32'h1041), mem_rd(32'h1040), mem_rd(32'h103F), mem_rd(32'h103E)}, 32'hAABBCCDD);
    chk("cross_write_held", sif.data_o, 32'hDEADBEEF);

    // Crossing read with a miss on the second line
    mem[32'h103D] = 8'h11; mem[32'h103E] = 8'h22; mem[32'h103F] = 8'h33; mem[32'h1040] = 8'h44;
    do_access(32'h103D, 32'h0, 4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 0);
    chk("cross_read_value", sif.data_o, 32'h44332211);

    // Wrap at the top of the address space
    do_access(32'hFFFF_FFFE, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 0, 0);

    // Read and write together, with requester inputs disturbed after capture
    do_access(32'h1FFD, 32'h01020304, 4'hB, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1, 0);
    do_access(32'h1010, 32'hCAFEF00D, 4'h6, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 0);

    // Back-to-back reads on adjacent lines
    do_access(32'h2000, 32'h0, 4'h0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 0, 0);
    do_access(32'h2040, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 0, 0);

    // Reset while the second line access is outstanding
    do_access(32'h203F, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 0, 1);
    do_access(32'h1004, 32'h0, 4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra   = 32'h4000 + 32'($urandom_range(0, 3)) * 32'd64
           + 32'(($urandom_range(0, 1) == 1) ? $urandom_range(60, 63) : $urandom_range(0, 63));
      rdat = $urandom;
      ren  = 4'($urandom);
      rw   = 2'($urandom_range(1, 3));
      do_access(ra, rdat, ren, rw[0], rw[1], int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/split_line_coupler.md
SPLIT_LINE_COUPLER -- requirements
Module: split_line_coupler

Interface
REQ-001 Parameter WORD_BYTES, default 4, meaning requester word width in bytes; power of 2, >= 1.
REQ-002 Parameter LINE_BYTES, default 64, meaning line width in bytes; power of 2, >= WORD_BYTES.
REQ-003 Parameter ADDRESS_SIZE, default 32, meaning address width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 short_in_if  mem_if.bus  LINE_BYTES=WORD_BYTES  requester side; addr, data_i, data_o, data_en, read_en, write_en, hit, done.
REQ-007 long_out_if  mem_if.driver  LINE_BYTES=LINE_BYTES  line-memory side; same fields at line width.

Function
REQ-008 Handshake, both sides: requester holds addr/data/enables steady until done is seen, then drops its enables the following cycle; done is a single-cycle pulse.
REQ-009 Derived values: offset = addr[log2(LINE_BYTES)-1:0]; base = addr with offset bits cleared; cross = (offset + WORD_BYTES > LINE_BYTES).
REQ-010 FSM states: IDLE, FIRST, GAP, SECOND, RESP.
REQ-011 IDLE: when read_en or write_en is high, capture addr, data_i, data_en, read_en and write_en, clear the hit accumulator to 1, and go to FIRST; otherwise remain in IDLE.
REQ-012 FIRST: drive long addr=base; data_i=captured data shifted left 8*offset bits and truncated to line width; data_en=captured data_en shifted left offset and truncated; enables=captured.
REQ-013 FIRST on long done: AND long hit into the accumulator; latch read bytes; go to SECOND via GAP if cross, else to RESP.
REQ-014 GAP: long read_en and write_en low for exactly one cycle; go to SECOND.
REQ-015 SECOND: long addr = base + LINE_BYTES modulo 2^ADDRESS_SIZE; data_i = captured data >> 8*(LINE_BYTES-offset); data_en = captured data_en >> (LINE_BYTES-offset); on long done AND hit, latch bytes, go to RESP.
REQ-016 Read assembly: word byte i = line byte offset+i from FIRST for offset+i < LINE_BYTES, else line byte offset+i-LINE_BYTES from SECOND.
REQ-017 RESP: short done=1 and short hit=accumulator for exactly one cycle; next state IDLE.
REQ-018 short data_o is registered, updated only on completion of an access with captured read_en=1, and held until the next such completion.
REQ-019 Long enables are low in IDLE, GAP and RESP; long addr/data_i/data_en are 0 in those states.
REQ-020 Short done is 0 outside RESP; short hit is 0 outside RESP.
REQ-021 Latency, non-crossing: request sampled cycle 0, FIRST from cycle 1, long done at cycle k, short done at cycle k+1.
REQ-022 Latency, crossing: done one cycle after SECOND's long done; exactly two long transactions per request.
REQ-023 read_en and write_en simultaneously high are both forwarded unchanged to each long transaction.
REQ-024 Changes to short inputs after capture have no effect until the next IDLE.

Reset
REQ-025 reset returns the FSM to IDLE on the next edge from any state, abandoning any in-flight access without asserting short done.
REQ-026 Reset values: data_o 0, hit accumulator 1, captured registers 0; all long outputs and short done/hit 0.

Verification (WORD_BYTES=4, LINE_BYTES=64, ADDRESS_SIZE=32)
REQ-027 Aligned read addr 0x1004, line bytes 4..7 = EF BE AD DE -> one long read at 0x1000; data_o=0xDEADBEEF; done one cycle after long done.
REQ-028 Crossing write 0x103E, data 0xAABBCCDD, en 0xF -> long 0x1000 with en bits 62,63 and bytes DD,CC; one GAP cycle with enables low; long 0x1040 with en 0x3 and bytes BB,AA.
REQ-029 Crossing read 0x103D, first line bytes 61..63 = 11,22,33, second line byte 0 = 44, second hit=0 -> data_o=0x44332211, hit=0.
REQ-030 Crossing read 0xFFFFFFFE -> second long addr 0x00000000.
REQ-031 reset asserted during SECOND -> long enables 0 next cycle, no short done, data_o=0.
REQ-032 Back-to-back reads 0x2000 then 0x2040 -> two independent completions; data_o holds first result until second done.
